// File: rtl/branch_sched.sv
// branch_sched: holds a D-stage branch on E/M hazards, resolves it and issues a registered redirect.
module branch_sched #(
    parameter int MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_valid,
    input  logic [3:0]  d_cmpop,
    input  logic [31:0] d_pc,
    input  logic [15:0] d_imm,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [4:0]  e_a3,
    input  logic [4:0]  m_a3,
    input  logic [1:0]  e_tnew,
    input  logic [1:0]  m_tnew,
    input  logic        stat_clr,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        wait_err,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_taken,
    output logic [31:0] stat_stalls
);
    localparam int CW = $clog2(MAX_WAIT + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_LIM = CW'(MAX_WAIT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          wait_err_q, wait_err_d;
    logic          redirect_q, redirect_d;
    logic [31:0]   redirect_pc_q, redirect_pc_d;
    logic [31:0]   stat_branches_q, stat_branches_d;
    logic [31:0]   stat_taken_q, stat_taken_d;
    logic [31:0]   stat_stalls_q, stat_stalls_d;
    logic          rt_used, haz_e, haz_m, resolve, taken, rs_zero;
    logic [31:0]   target;

    assign rt_used = d_cmpop == 4'd0 || d_cmpop == 4'd5;
    assign haz_e   = e_a3 != 5'd0 && e_tnew != 2'd0 && (e_a3 == d_rs || (rt_used && e_a3 == d_rt));
    assign haz_m   = m_a3 != 5'd0 && m_tnew != 2'd0 && (m_a3 == d_rs || (rt_used && m_a3 == d_rt));
    assign stall   = d_valid && (haz_e || haz_m);
    assign resolve = d_valid && !stall;
    assign rs_zero = rs_val == 32'd0;
    assign target  = d_pc + 32'd4 + {{14{d_imm[15]}}, d_imm, 2'b00};

    // Sign bit and zero test cover all signed compares against zero.
    assign taken = d_cmpop == 4'd0 ? rs_val == rt_val :
                   d_cmpop == 4'd5 ? rs_val != rt_val :
                   d_cmpop == 4'd1 ? !rs_val[31] :
                   d_cmpop == 4'd2 ? rs_val[31] :
                   d_cmpop == 4'd3 ? !rs_val[31] && !rs_zero :
                   d_cmpop == 4'd4 ? rs_val[31] || rs_zero : 1'b0;

    always_comb begin
        state_d         = stall ? S_WAIT : S_IDLE;
        wait_cnt_d      = !stall || state_q == S_IDLE ? '0 :
                          wait_cnt_q == CNT_MAX ? CNT_MAX : wait_cnt_q + 1'b1;
        wait_err_d      = wait_err_q || (state_q == S_WAIT && stall && wait_cnt_q >= CNT_LIM);
        redirect_d      = resolve && taken;
        redirect_pc_d   = resolve && taken ? target : redirect_pc_q;
        stat_branches_d = stat_clr ? '0 : resolve && ~&stat_branches_q ? stat_branches_q + 32'd1 : stat_branches_q;
        stat_taken_d    = stat_clr ? '0 : resolve && taken && ~&stat_taken_q ? stat_taken_q + 32'd1 : stat_taken_q;
        stat_stalls_d   = stat_clr ? '0 : stall && ~&stat_stalls_q ? stat_stalls_q + 32'd1 : stat_stalls_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            wait_cnt_q      <= '0;
            wait_err_q      <= 1'b0;
            redirect_q      <= 1'b0;
            redirect_pc_q   <= 32'h0000_3000;
            stat_branches_q <= '0;
            stat_taken_q    <= '0;
            stat_stalls_q   <= '0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            wait_err_q      <= wait_err_d;
            redirect_q      <= redirect_d;
            redirect_pc_q   <= redirect_pc_d;
            stat_branches_q <= stat_branches_d;
            stat_taken_q    <= stat_taken_d;
            stat_stalls_q   <= stat_stalls_d;
        end
    end

    assign redirect      = redirect_q;
    assign redirect_pc   = redirect_pc_q;
    assign wait_err      = wait_err_q;
    assign stat_branches = stat_branches_q;
    assign stat_taken    = stat_taken_q;
    assign stat_stalls   = stat_stalls_q;
endmodule

// File: tb/tb_branch_sched.sv
// tb_branch_sched: directed test-plan cases plus random traffic against a behavioural model.
module tb_branch_sched;
    localparam int MAX_WAIT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        d_valid = 1'b0;
    logic [3:0]  d_cmpop = '0;
    logic [31:0] d_pc = '0;
    logic [15:0] d_imm = '0;
    logic [4:0]  d_rs = '0, d_rt = '0, e_a3 = '0, m_a3 = '0;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic [1:0]  e_tnew = '0, m_tnew = '0;
    logic        stat_clr = 1'b0;
    logic        stall, redirect, wait_err;
    logic [31:0] redirect_pc, stat_branches, stat_taken, stat_stalls;

    int n_chk = 0;
    int n_fail = 0;

    logic        x_redir;
    logic [31:0] x_pc;
    logic        x_err;
    longint      x_br, x_tk, x_st;
    int          ep;

    branch_sched #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_cmpop(d_cmpop), .d_pc(d_pc),
        .d_imm(d_imm), .d_rs(d_rs), .d_rt(d_rt), .rs_val(rs_val), .rt_val(rt_val),
        .e_a3(e_a3), .m_a3(m_a3), .e_tnew(e_tnew), .m_tnew(m_tnew), .stat_clr(stat_clr),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .wait_err(wait_err),
        .stat_branches(stat_branches), .stat_taken(stat_taken), .stat_stalls(stat_stalls)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_haz(input logic [4:0] a3, input logic [1:0] tn);
        bit use_rt;
        use_rt = d_cmpop == 4'd0 || d_cmpop == 4'd5;
        return a3 != 0 && tn != 0 && (a3 == d_rs || (use_rt && a3 == d_rt));
    endfunction

    function automatic bit m_stall();
        return d_valid && (m_haz(e_a3, e_tnew) || m_haz(m_a3, m_tnew));
    endfunction

    function automatic bit m_taken();
        case (d_cmpop)
            4'd0: return rs_val == rt_val;
            4'd5: return rs_val != rt_val;
            4'd1: return $signed(rs_val) >= 0;
            4'd2: return $signed(rs_val) < 0;
            4'd3: return $signed(rs_val) > 0;
            4'd4: return $signed(rs_val) <= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_target();
        int off;
        off = int'($signed(d_imm)) * 4;
        return d_pc + 32'd4 + 32'(off);
    endfunction

    function automatic longint sat(input longint v);
        return v < 64'hFFFF_FFFF ? v + 1 : v;
    endfunction

    task automatic model_reset();
        x_redir = 1'b0; x_pc = 32'h0000_3000; x_err = 1'b0;
        x_br = 0; x_tk = 0; x_st = 0; ep = 0;
    endtask

    task automatic check_outs(input string where);
        check({where, ".redirect"}, {31'd0, redirect}, {31'd0, x_redir});
        check({where, ".redirect_pc"}, redirect_pc, x_pc);
        check({where, ".wait_err"}, {31'd0, wait_err}, {31'd0, x_err});
        check({where, ".stat_branches"}, stat_branches, x_br[31:0]);
        check({where, ".stat_taken"}, stat_taken, x_tk[31:0]);
        check({where, ".stat_stalls"}, stat_stalls, x_st[31:0]);
    endtask

    // Inputs are already applied; check stall, clock once, update model, check registered outputs.
    task automatic tick(input string where);
        bit s, r, t;
        #1;
        s = m_stall();
        check({where, ".stall"}, {31'd0, stall}, {31'd0, s});
        @(posedge clk);
        r = d_valid && !s;
        t = r && m_taken();
        x_redir = t;
        if (t) x_pc = m_target();
        ep = s ? ep + 1 : 0;
        if (ep >= MAX_WAIT + 2) x_err = 1'b1;
        if (stat_clr) begin
            x_br = 0; x_tk = 0; x_st = 0;
        end else begin
            if (r) x_br = sat(x_br);
            if (t) x_tk = sat(x_tk);
            if (s) x_st = sat(x_st);
        end
        #1;
        check_outs(where);
    endtask

    task automatic br(input logic v, input logic [3:0] op, input logic [31:0] pc, input logic [15:0] imm,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rsv, input logic [31:0] rtv);
        d_valid = v; d_cmpop = op; d_pc = pc; d_imm = imm;
        d_rs = rs; d_rt = rt; rs_val = rsv; rt_val = rtv;
    endtask

    task automatic haz(input logic [4:0] ea, input logic [1:0] et, input logic [4:0] ma, input logic [1:0] mt);
        e_a3 = ea; e_tnew = et; m_a3 = ma; m_tnew = mt;
    endtask

    task automatic rand_in();
        int k;
        d_valid = $urandom_range(0, 9) != 0;
        d_cmpop = 4'($urandom_range(0, 7));
        d_pc = $urandom;
        d_imm = 16'($urandom);
        d_rs = 5'($urandom_range(0, 5));
        d_rt = 5'($urandom_range(0, 5));
        k = $urandom_range(0, 4);
        rs_val = k == 0 ? 32'd0 : k == 1 ? 32'hFFFF_FFFF : k == 2 ? 32'd1 : k == 3 ? 32'h8000_0000 : $urandom;
        rt_val = $urandom_range(0, 1) ? rs_val : $urandom;
        e_a3 = 5'($urandom_range(0, 5));
        m_a3 = 5'($urandom_range(0, 5));
        e_tnew = 2'($urandom_range(0, 2));
        m_tnew = 2'($urandom_range(0, 1));
        stat_clr = $urandom_range(0, 49) == 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset");
        reset = 1'b0;

        br(1, 4'd0, 32'h3000, 16'h0004, 5'd1, 5'd2, 32'd5, 32'd5);
        haz(0, 0, 0, 0);
        tick("beq");
        check("beq_pc", redirect_pc, 32'h3014);

        br(1, 4'd5, 32'h4000, 16'h0010, 5'd1, 5'd2, 32'd5, 32'd5);
        tick("bne_eq");
        check("bne_hold_pc", redirect_pc, 32'h3014);

        br(1, 4'd3, 32'h5000, 16'h0002, 5'd8, 5'd0, 32'hFFFF_FFFF, 32'd0);
        haz(5'd8, 2'd2, 0, 0); tick("bgtz_s1");
        haz(5'd8, 2'd1, 0, 0); tick("bgtz_s2");
        haz(0, 0, 5'd8, 2'd0); tick("bgtz_res");
        check("bgtz_stalls", stat_stalls, 32'd2);

        br(1, 4'd1, 32'h3000, 16'h8000, 5'd3, 5'd0, 32'd0, 32'd0);
        haz(0, 0, 0, 0);
        tick("wrap");
        check("wrap_pc", redirect_pc, 32'hFFFE_3004);
        br(1, 4'd2, 32'h100, 16'hFFFF, 5'd3, 5'd0, 32'h8000_0000, 32'd0);
        tick("b2b");
        check("b2b_redirect", {31'd0, redirect}, 32'd1);

        br(1, 4'd4, 32'h6000, 16'h0001, 5'd9, 5'd0, 32'd0, 32'd0);
        haz(0, 0, 5'd9, 2'd1);
        tick("flush_s1"); tick("flush_s2");
        d_valid = 1'b0;
        tick("flush_drop"); tick("flush_idle");

        br(1, 4'd0, 32'h7000, 16'h0003, 5'd4, 5'd6, 32'd7, 32'd7);
        haz(5'd6, 2'd2, 0, 0);
        for (int i = 0; i < 5; i++) tick("werr_stall");
        haz(0, 0, 0, 0);
        tick("werr_res");
        check("werr_sticky", {31'd0, wait_err}, 32'd1);
        d_valid = 1'b0;
        tick("werr_idle");

        br(1, 4'd0, 32'h7000, 16'h0003, 5'd4, 5'd6, 32'd7, 32'd7);
        haz(5'd4, 2'd1, 0, 0);
        tick("rst_s1"); tick("rst_s2");
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_outs("rst_async");
        haz(0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_outs("rst_hold");
        reset = 1'b0;
        d_valid = 1'b0;
        tick("rst_after");

        for (int i = 0; i < 3000; i++) begin
            rand_in();
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
